// File: rtl/controle_pkg.sv
// controle_pkg: opcodes, FSM states and IR field positions
// shared by the multi-cycle control unit and its decoder.
package controle_pkg;

  localparam int OPC_LSB = 27;
  localparam int RD_LSB  = 22;
  localparam int RS1_LSB = 17;
  localparam int RS2_LSB = 12;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    OCIOSO,
    BUSCA,
    ESPERA_MEM,
    DECODIFICA,
    EXECUTA,
    ESCRITA,
    PARADO
  } estado_t;

endpackage

// File: rtl/unidade_controle_multiciclo_decodificador_opcode.sv
// decodificador_opcode: opcode -> one-hot class
// in: opcode; out: eh_add, eh_nop, eh_halt, eh_ilegal.
module decodificador_opcode
  import controle_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic                eh_add,
  output logic                eh_nop,
  output logic                eh_halt,
  output logic                eh_ilegal
);

  always_comb begin
    eh_add    = 1'b0;
    eh_nop    = 1'b0;
    eh_halt   = 1'b0;
    eh_ilegal = 1'b0;
    unique case (1'b1)
      (opcode == OPCODE_W'(OP_ADD)):  eh_add  = 1'b1;
      (opcode == OPCODE_W'(OP_NOP)):  eh_nop  = 1'b1;
      (opcode == OPCODE_W'(OP_HALT)): eh_halt = 1'b1;
      default:                        eh_ilegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: fetch/decode/execute/write sequencer
// in: clock, reset, inicia, pausa, instrucao; out: strobes, IR fields, status, counter.
module unidade_controle_multiciclo
  import controle_pkg::*;
#(
  parameter int INSTR_W      = 32,
  parameter int OPCODE_W     = 5,
  parameter int REG_ADDR_W   = 5,
  parameter int MEM_LATENCIA = 1,
  parameter int CONT_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inicia,
  input  logic                  pausa,
  input  logic [INSTR_W-1:0]    instrucao,
  output logic                  mem_le,
  output logic                  pc_incrementa,
  output logic [OPCODE_W-1:0]   ula_opcode,
  output logic                  reg_escreve,
  output logic [REG_ADDR_W-1:0] endereco_regd,
  output logic [REG_ADDR_W-1:0] endereco_reg1,
  output logic [REG_ADDR_W-1:0] endereco_reg2,
  output logic                  ocupado,
  output logic                  parado,
  output logic                  erro_opcode,
  output logic [CONT_W-1:0]     contador_instrucoes
);

  localparam int ESP_W = 3;

  estado_t             estado;
  estado_t             prox;
  logic [INSTR_W-1:0]  ir;
  logic [ESP_W-1:0]    espera;
  logic [CONT_W-1:0]   cont;
  logic                erro;
  logic [OPCODE_W-1:0] op_ir;
  logic                retira;
  logic                marca_erro;
  logic                eh_add;
  logic                eh_nop;
  logic                eh_halt;
  logic                eh_ilegal;

  assign op_ir = ir[OPC_LSB +: OPCODE_W];

  decodificador_opcode #(
    .OPCODE_W (OPCODE_W)
  ) u_dec (
    .opcode    (op_ir),
    .eh_add    (eh_add),
    .eh_nop    (eh_nop),
    .eh_halt   (eh_halt),
    .eh_ilegal (eh_ilegal)
  );

  always_comb begin
    prox          = estado;
    mem_le        = 1'b0;
    pc_incrementa = 1'b0;
    reg_escreve   = 1'b0;
    ula_opcode    = '0;
    retira        = 1'b0;
    marca_erro    = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (inicia) prox = BUSCA;
      end
      BUSCA: begin
        if (!pausa) begin
          mem_le = 1'b1;
          prox   = ESPERA_MEM;
        end
      end
      ESPERA_MEM: begin
        // dwell ends on the cycle the counter would hit zero
        if (espera <= ESP_W'(1)) prox = DECODIFICA;
      end
      DECODIFICA: prox = EXECUTA;
      EXECUTA: begin
        ula_opcode = op_ir;
        unique case (1'b1)
          eh_add: prox = ESCRITA;
          eh_nop: begin
            pc_incrementa = 1'b1;
            retira        = 1'b1;
            prox          = BUSCA;
          end
          eh_halt: begin
            retira = 1'b1;
            prox   = PARADO;
          end
          eh_ilegal: begin
            marca_erro = 1'b1;
            prox       = PARADO;
          end
          default: prox = PARADO;
        endcase
      end
      ESCRITA: begin
        ula_opcode    = op_ir;
        reg_escreve   = 1'b1;
        pc_incrementa = 1'b1;
        retira        = 1'b1;
        prox          = BUSCA;
      end
      PARADO:  prox = PARADO;
      default: prox = OCIOSO;
    endcase
    // reset suppresses strobes in the very cycle it is raised
    if (reset) begin
      mem_le        = 1'b0;
      pc_incrementa = 1'b0;
      reg_escreve   = 1'b0;
      ula_opcode    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
      ir     <= '0;
      espera <= '0;
      cont   <= '0;
      erro   <= 1'b0;
    end else begin
      estado <= prox;
      if (estado == BUSCA && !pausa)
        espera <= ESP_W'(MEM_LATENCIA);
      else if (estado == ESPERA_MEM)
        espera <= espera - ESP_W'(1);
      if (estado == DECODIFICA)
        ir <= instrucao;
      if (retira && cont != '1)
        cont <= cont + CONT_W'(1);
      if (marca_erro)
        erro <= 1'b1;
    end
  end

  assign endereco_regd       = ir[RD_LSB  +: REG_ADDR_W];
  assign endereco_reg1       = ir[RS1_LSB +: REG_ADDR_W];
  assign endereco_reg2       = ir[RS2_LSB +: REG_ADDR_W];
  assign ocupado             = (estado != OCIOSO) && (estado != PARADO);
  assign parado              = (estado == PARADO);
  assign erro_opcode         = erro;
  assign contador_instrucoes = cont;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// tb_unidade_controle_multiciclo: randomized bench with instruction-level model
// drives two instances (L=1/CONT_W=16 and L=3/CONT_W=2) on shared inputs.
module tb_unidade_controle_multiciclo;

  logic        clock = 1'b0;
  logic        reset;
  logic        inicia;
  logic        pausa;
  logic [31:0] instrucao;

  logic        a_mem, a_pc, a_reg, a_ocup, a_par, a_err;
  logic [4:0]  a_ula, a_rd, a_r1, a_r2;
  logic [15:0] a_cnt;
  logic        b_mem, b_pc, b_reg, b_ocup, b_par, b_err;
  logic [4:0]  b_ula, b_rd, b_r1, b_r2;
  logic [1:0]  b_cnt;

  int          passed = 0;
  int          total  = 0;
  int          sel;
  int          lat;
  int          cmax;
  int          m_cnt;
  bit          m_err;
  logic [31:0] m_ir;
  logic [31:0] w;

  always #5 clock = ~clock;

  unidade_controle_multiciclo #(
    .MEM_LATENCIA (1),
    .CONT_W       (16)
  ) dut_a (
    .clock               (clock),
    .reset               (reset),
    .inicia              (inicia),
    .pausa               (pausa),
    .instrucao           (instrucao),
    .mem_le              (a_mem),
    .pc_incrementa       (a_pc),
    .ula_opcode          (a_ula),
    .reg_escreve         (a_reg),
    .endereco_regd       (a_rd),
    .endereco_reg1       (a_r1),
    .endereco_reg2       (a_r2),
    .ocupado             (a_ocup),
    .parado              (a_par),
    .erro_opcode         (a_err),
    .contador_instrucoes (a_cnt)
  );

  unidade_controle_multiciclo #(
    .MEM_LATENCIA (3),
    .CONT_W       (2)
  ) dut_b (
    .clock               (clock),
    .reset               (reset),
    .inicia              (inicia),
    .pausa               (pausa),
    .instrucao           (instrucao),
    .mem_le              (b_mem),
    .pc_incrementa       (b_pc),
    .ula_opcode          (b_ula),
    .reg_escreve         (b_reg),
    .endereco_regd       (b_rd),
    .endereco_reg1       (b_r1),
    .endereco_reg2       (b_r2),
    .ocupado             (b_ocup),
    .parado              (b_par),
    .erro_opcode         (b_err),
    .contador_instrucoes (b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit rb();
    return bit'($urandom % 2);
  endfunction

  task automatic bump();
    if (m_cnt < cmax) m_cnt++;
  endtask

  // one clock: apply inputs, compare at the falling edge, advance
  task automatic cyc(input bit p, input bit ini, input bit rst,
                     input bit mem, input bit pc, input bit rg,
                     input logic [4:0] ula, input bit busy, input bit halt);
    logic [31:0] o_s, o_c, o_a, e_s, e_a;
    pausa  = p;
    inicia = ini;
    reset  = rst;
    @(negedge clock);
    if (sel == 0) begin
      o_s = {21'd0, a_mem, a_pc, a_reg, a_ula, a_ocup, a_par, a_err};
      o_c = {16'd0, a_cnt};
      o_a = {17'd0, a_rd, a_r1, a_r2};
    end else begin
      o_s = {21'd0, b_mem, b_pc, b_reg, b_ula, b_ocup, b_par, b_err};
      o_c = {30'd0, b_cnt};
      o_a = {17'd0, b_rd, b_r1, b_r2};
    end
    e_s = {21'd0, mem, pc, rg, ula, busy, halt, m_err};
    e_a = {17'd0, m_ir[26:22], m_ir[21:17], m_ir[16:12]};
    check("sinais", o_s, e_s);
    check("contador", o_c, m_cnt);
    check("enderecos", o_a, e_a);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(rb(), 1'b0, 1'b0, 0, 0, 0, 5'd0, 0, 0);
  endtask

  task automatic start();
    cyc(rb(), 1'b1, 1'b0, 0, 0, 0, 5'd0, 0, 0);
  endtask

  task automatic halted(input int n);
    for (int i = 0; i < n; i++) begin
      instrucao = $urandom;
      cyc(rb(), rb(), 1'b0, 0, 0, 0, 5'd0, 0, 1);
    end
  endtask

  task automatic do_reset(input int s);
    sel  = s;
    lat  = (s != 0) ? 3 : 1;
    cmax = (s != 0) ? 3 : 65535;
    reset     = 1'b1;
    inicia    = rb();
    pausa     = rb();
    instrucao = $urandom;
    @(posedge clock);
    #1;
    m_cnt = 0;
    m_err = 1'b0;
    m_ir  = '0;
    cyc(rb(), 1'b1, 1'b1, 0, 0, 0, 5'd0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 5'd0, 0, 0);
  endtask

  // whole instruction as seen from its first BUSCA cycle
  task automatic instr(input logic [31:0] wd, input int npause,
                       input bit abort_wr);
    logic [4:0] op;
    op = wd[31:27];
    for (int i = 0; i < npause; i++) begin
      instrucao = $urandom;
      cyc(1'b1, rb(), 1'b0, 0, 0, 0, 5'd0, 1, 0);
    end
    instrucao = $urandom;
    cyc(1'b0, rb(), 1'b0, 1, 0, 0, 5'd0, 1, 0);
    for (int i = 0; i < lat; i++) begin
      instrucao = $urandom;
      cyc(rb(), rb(), 1'b0, 0, 0, 0, 5'd0, 1, 0);
    end
    instrucao = wd;
    cyc(rb(), rb(), 1'b0, 0, 0, 0, 5'd0, 1, 0);
    m_ir = wd;
    instrucao = $urandom;
    if (op == 5'b00001) begin
      cyc(rb(), rb(), 1'b0, 0, 0, 0, op, 1, 0);
      if (abort_wr) begin
        cyc(rb(), 1'b1, 1'b1, 0, 0, 0, 5'd0, 1, 0);
        m_cnt = 0;
        m_err = 1'b0;
        m_ir  = '0;
      end else begin
        cyc(rb(), rb(), 1'b0, 0, 1, 1, op, 1, 0);
        bump();
      end
    end else if (op == 5'b00000) begin
      cyc(rb(), rb(), 1'b0, 0, 1, 0, op, 1, 0);
      bump();
    end else if (op == 5'b11111) begin
      cyc(rb(), rb(), 1'b0, 0, 0, 0, op, 1, 0);
      bump();
    end else begin
      cyc(rb(), rb(), 1'b0, 0, 0, 0, op, 1, 0);
      m_err = 1'b1;
    end
  endtask

  initial begin
    do_reset(0);
    start();
    instr(32'h0880_1000, 0, 1'b0);
    instr({5'd0, 27'($urandom)}, 0, 1'b0);
    instr({5'd1, 27'($urandom)}, 5, 1'b0);
    for (int i = 0; i < 20; i++) begin
      w = {($urandom % 2 != 0) ? 5'd1 : 5'd0, 27'($urandom)};
      instr(w, $urandom_range(0, 3), 1'b0);
    end
    instr({5'd31, 27'($urandom)}, 0, 1'b0);
    halted(6);

    do_reset(0);
    start();
    instr({5'd1, 27'($urandom)}, 0, 1'b1);
    idle(2);
    start();
    instr(32'h5000_0000, 1, 1'b0);
    halted(4);

    do_reset(0);
    start();
    w = {5'($urandom_range(2, 30)), 27'($urandom)};
    instr(w, 2, 1'b0);
    halted(3);

    do_reset(0);
    start();
    instr({5'd0, 27'($urandom)}, 0, 1'b0);
    instr({5'd1, 27'($urandom)}, 1, 1'b0);
    instr({5'd31, 27'($urandom)}, 0, 1'b0);
    halted(4);

    do_reset(1);
    start();
    for (int i = 0; i < 5; i++)
      instr({5'd0, 27'($urandom)}, 0, 1'b0);
    instr({5'd31, 27'($urandom)}, 0, 1'b0);
    halted(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
